johnson_decoder: RTL and testbench
==================================

# johnson_decoder

Receive-side companion to the team's Johnson counter. Takes the counter's N-bit registered Johnson code, re-registers it and decodes it to a binary index and a one-hot vector. It flags illegal codes, checks that each code is the exact successor of the last, and runs a lock state machine with a saturating error counter. It sits in the consumer clock domain, on the same clock as the counter, wherever a phase/slot index is derived from a Johnson ring.

## Interface
- N, 4, Johnson code width; 2N states; N ≥ 2
- IW, $clog2(2N), index width (3 for N=4)
- LOCK_CNT, 4, consecutive good successor steps required to lock; 1..15
- clk  in  1  clock; all logic on rising edge
- n_rst  in  1  **one clock; reset is asynchronous and active-low**, all state cleared immediately on assertion
- j_in  in  N  Johnson code; bit 0 is the stage fed by ~bit N-1
- clr_err  in  1  synchronous clear of err_cnt
- idx_out  out  IW  decoded index 0..2N-1
- onehot_out  out  2N  one-hot of idx_out; all-zero when code illegal
- valid_out  out  1  decoded code was legal
- locked  out  1  lock FSM in LOCKED
- seq_err  out  1  one-cycle pulse: sequence error while LOCKED
- err_cnt  out  8  count of seq_err pulses, saturates at 255

## Operation
- Stage 1: j_in registered into j_r (reset 0).
- Stage 2: code check on j_r (p = popcount):
  - Legal iff j_r is thermometer-from-bit-0 (p ones in bits p-1..0) or thermometer-from-bit-N-1 (p ones in bits N-1..N-p).
  - Legal codes for N=4, as bits 3..0: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - idx = p if j_r[0]=1; otherwise (2N−p) mod 2N. Result: 0000→0, 1111→4, 1000→7.
- Legal code: idx_out=idx, onehot_out=1<<idx, valid_out=1.
- Illegal code: idx_out=0, onehot_out=0, valid_out=0.
- prev_idx and prev_ok registers hold the last legal index. Step is good iff legal, prev_ok=1 and idx == (prev_idx+1) mod 2N. Wrap 2N−1→0 is good.
- Lock FSM states: SEARCH (reset), ACQUIRE, LOCKED. good_cnt is 4 bits.
  - Illegal code from any state: go to SEARCH, prev_ok=0, good_cnt=0.
  - Legal code in SEARCH: go to ACQUIRE, good_cnt=0.
  - Good step in ACQUIRE: good_cnt+1. Reaching LOCK_CNT goes to LOCKED.
  - Legal but non-successor code in ACQUIRE: stay in ACQUIRE, good_cnt=0 (new reference).
  - Good step in LOCKED: stay.
  - Legal non-successor in LOCKED: seq_err=1, go to ACQUIRE, good_cnt=0.
  - Illegal code in LOCKED: seq_err=1, go to SEARCH.
- Every legal code sets prev_idx=idx and prev_ok=1.
- err_cnt increments on seq_err and saturates at 255. clr_err=1 forces err_cnt=0; this takes priority over a simultaneous increment, though the seq_err pulse still appears.
- Repeated code (counter stalled) is a legal non-successor and is handled as above.

## Timing
- Reset values: j_r=0, idx_out=0, onehot_out=0, valid_out=0, locked=0, seq_err=0, err_cnt=0, FSM=SEARCH, prev_ok=0.
- Latency: j_in sampled at edge k appears on idx_out/onehot_out/valid_out at edge k+1. locked, seq_err and err_cnt update on the same edge k+1.
- Lock time: locked rises on the edge decoding the (LOCK_CNT+1)-th consecutive legal successor code. After reset release with a running counter, that is edge 6 for LOCK_CNT=4.
- seq_err is high exactly one cycle per error event.
- n_rst asserted mid-operation clears everything asynchronously. After release, lock is reacquired per the rule above.

## Structure
- Shared package/header johnson_pkg:
  - FSM state encodings (SEARCH=0, ACQUIRE=1, LOCKED=2)
  - Default N
  - ERR_MAX=255
- Sub-module johnson_code_check: purely combinational, N-bit code → legal, idx. It is reused by any future Johnson consumer.
- Top module: stage registers, prev registers, FSM, err counter.

## Test plan
- Drive the legal sequence 0000,0001,…,1000, repeating from reset release, N=4, LOCK_CNT=4 -> idx_out follows 0..7 two edges behind j_in, locked rises on edge 6, seq_err never asserts.
- Once locked, inject 1010 for one cycle, then resume the sequence -> valid_out=0, onehot_out=0, seq_err pulse, err_cnt=1, FSM goes to SEARCH, locked relocks 5 legal codes later.
- Once locked, skip from 0011 to 1111 -> seq_err pulse, err_cnt increments, ACQUIRE, relock after 4 further good steps.
- Hold j_in at 0111 for 3 cycles while locked -> one seq_err, then ACQUIRE with good_cnt held at 0, no further seq_err, never locks.
- Force 300 lock/error cycles -> err_cnt saturates at 255. Assert clr_err together with a seq_err -> err_cnt=0 and seq_err still pulses.
- Assert n_rst mid-stream -> all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared definitions for Johnson-ring consumers: lock FSM encoding and limits.
package johnson_pkg;

  localparam int N_DEFAULT = 4;
  localparam int ERR_MAX   = 255;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_e;

endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson code classifier: flags legal codes and maps them to
// their ring index (0..2N-1).
module johnson_code_check #(
  parameter int N  = 4,
  parameter int IW = $clog2(2*N)
) (
  input  logic [N-1:0]  code_i,
  output logic          legal_o,
  output logic [IW-1:0] idx_o
);

  localparam int           TWO_N = 2*N;
  localparam logic [N-1:0] ONES  = '1;

  logic [N:0] lo_hit;
  logic [N:0] hi_hit;

  // Pattern gi holds gi ones, filled either from bit 0 or from bit N-1.
  genvar gi;
  generate
    for (gi = 0; gi <= N; gi++) begin : g_pat
      localparam logic [N-1:0] LO_PAT = ONES >> (N - gi);
      localparam logic [N-1:0] HI_PAT = ~(ONES >> gi);
      assign lo_hit[gi] = (code_i == LO_PAT);
      assign hi_hit[gi] = (code_i == HI_PAT);
    end
  endgenerate

  always_comb begin
    legal_o = 1'b0;
    idx_o   = '0;
    for (int p = 0; p <= N; p++) begin
      if (lo_hit[p] || hi_hit[p]) begin
        legal_o = 1'b1;
        idx_o   = code_i[0] ? IW'(p) : IW'((TWO_N - p) % TWO_N);
      end
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Re-registers a Johnson code, decodes it to index/one-hot, and tracks ring
// lock with successor checking and a saturating sequence-error counter.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int LOCK_CNT = 4,
  parameter int IW       = $clog2(2*N)
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [N-1:0]    j_in,
  input  logic            clr_err,
  output logic [IW-1:0]   idx_out,
  output logic [2*N-1:0]  onehot_out,
  output logic            valid_out,
  output logic            locked,
  output logic            seq_err,
  output logic [7:0]      err_cnt
);

  localparam int               TWO_N   = 2*N;
  localparam logic [TWO_N-1:0] ONE_HOT = TWO_N'(1);

  logic [N-1:0]     j_q;
  logic [IW-1:0]    idx_q;
  logic [TWO_N-1:0] onehot_q;
  logic             valid_q;
  logic             seq_err_q;
  logic [7:0]       err_cnt_q;
  logic [IW-1:0]    prev_idx_q;
  logic             prev_ok_q;
  logic [3:0]       good_cnt_q;
  lock_state_e      state_q;

  logic             legal;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    next_idx_d;
  logic             good_step_d;
  logic             seq_err_d;

  johnson_code_check #(
    .N  (N),
    .IW (IW)
  ) u_code_check (
    .code_i  (j_q),
    .legal_o (legal),
    .idx_o   (idx)
  );

  assign next_idx_d  = (prev_idx_q == IW'(TWO_N - 1)) ? '0 : prev_idx_q + IW'(1);
  assign good_step_d = legal && prev_ok_q && (idx == next_idx_d);
  // Any departure from the successor chain while locked is an error event.
  assign seq_err_d   = (state_q == LOCKED) && !good_step_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      j_q        <= '0;
      idx_q      <= '0;
      onehot_q   <= '0;
      valid_q    <= 1'b0;
      seq_err_q  <= 1'b0;
      err_cnt_q  <= '0;
      prev_idx_q <= '0;
      prev_ok_q  <= 1'b0;
      good_cnt_q <= '0;
      state_q    <= SEARCH;
    end else begin
      j_q       <= j_in;
      valid_q   <= legal;
      idx_q     <= legal ? idx : '0;
      onehot_q  <= legal ? (ONE_HOT << idx) : '0;
      seq_err_q <= seq_err_d;

      if (legal) begin
        prev_idx_q <= idx;
        prev_ok_q  <= 1'b1;
      end else begin
        prev_ok_q  <= 1'b0;
      end

      case (state_q)
        SEARCH: begin
          good_cnt_q <= '0;
          if (legal) state_q <= ACQUIRE;
        end
        ACQUIRE: begin
          if (!legal) begin
            state_q    <= SEARCH;
            good_cnt_q <= '0;
          end else if (good_step_d) begin
            good_cnt_q <= good_cnt_q + 4'd1;
            if (good_cnt_q == 4'(LOCK_CNT - 1)) state_q <= LOCKED;
          end else begin
            good_cnt_q <= '0;
          end
        end
        LOCKED: begin
          if (!legal) begin
            state_q    <= SEARCH;
            good_cnt_q <= '0;
          end else if (!good_step_d) begin
            state_q    <= ACQUIRE;
            good_cnt_q <= '0;
          end
        end
        default: begin
          state_q    <= SEARCH;
          good_cnt_q <= '0;
        end
      endcase

      if (clr_err) begin
        err_cnt_q <= '0;
      end else if (seq_err_d && (err_cnt_q != 8'(ERR_MAX))) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign idx_out    = idx_q;
  assign onehot_out = onehot_q;
  assign valid_out  = valid_q;
  assign locked     = (state_q == LOCKED);
  assign seq_err    = seq_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (N=4, LOCK_CNT=4).
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] j_in = 4'b0000;
  logic       clr_err = 1'b0;
  logic [2:0] idx_out;
  logic [7:0] onehot_out;
  logic       valid_out;
  logic       locked;
  logic       seq_err;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int pos = 0;
  logic [3:0] codes [8];

  johnson_decoder #(
    .N        (4),
    .LOCK_CNT (4)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .j_in       (j_in),
    .clr_err    (clr_err),
    .idx_out    (idx_out),
    .onehot_out (onehot_out),
    .valid_out  (valid_out),
    .locked     (locked),
    .seq_err    (seq_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic [3:0] c);
    j_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_next();
    tick(codes[pos]);
    pos = (pos + 1) % 8;
  endtask

  task automatic test_reset();
    j_in = 4'b0111;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (idx_out !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", idx_out); end
    checks++; if (onehot_out !== 8'h00) begin errors++; $display("FAIL reset_onehot got %h want 00", onehot_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_out); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err got %b want 0", seq_err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    @(negedge clk);
    n_rst = 1'b1;
    pos = 0;
  endtask

  task automatic test_lock();
    logic [2:0] exp_idx;
    logic [7:0] exp_oh;
    for (int e = 1; e <= 16; e++) begin
      tick_next();
      exp_idx = (e < 2) ? 3'd0 : 3'((e - 2) % 8);
      exp_oh  = 8'd1 << exp_idx;
      checks++; if (idx_out !== exp_idx) begin errors++; $display("FAIL lock_idx edge %0d got %0d want %0d", e, idx_out, exp_idx); end
      checks++; if (onehot_out !== exp_oh) begin errors++; $display("FAIL lock_onehot edge %0d got %h want %h", e, onehot_out, exp_oh); end
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL lock_valid edge %0d got %b want 1", e, valid_out); end
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL lock_seq_err edge %0d got %b want 0", e, seq_err); end
      checks++; if (locked !== (e >= 6)) begin errors++; $display("FAIL lock_locked edge %0d got %b want %b", e, locked, (e >= 6)); end
    end
  endtask

  task automatic test_illegal();
    tick(4'b1010);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL ill_pre_locked got %b want 1", locked); end
    for (int k = 1; k <= 6; k++) begin
      tick_next();
      if (k == 1) begin
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL ill_valid got %b want 0", valid_out); end
        checks++; if (onehot_out !== 8'h00) begin errors++; $display("FAIL ill_onehot got %h want 00", onehot_out); end
        checks++; if (idx_out !== 3'd0) begin errors++; $display("FAIL ill_idx got %0d want 0", idx_out); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL ill_err_cnt got %0d want 1", err_cnt); end
      end
      checks++; if (seq_err !== (k == 1)) begin errors++; $display("FAIL ill_seq_err step %0d got %b want %b", k, seq_err, (k == 1)); end
      checks++; if (locked !== (k == 6)) begin errors++; $display("FAIL ill_locked step %0d got %b want %b", k, locked, (k == 6)); end
    end
  endtask

  task automatic test_skip();
    while (pos != 3) tick_next();
    tick(4'b1111);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL skip_pre_locked got %b want 1", locked); end
    pos = 5;
    for (int k = 1; k <= 5; k++) begin
      tick_next();
      if (k == 1) begin
        checks++; if (idx_out !== 3'd4) begin errors++; $display("FAIL skip_idx got %0d want 4", idx_out); end
        checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL skip_err_cnt got %0d want 2", err_cnt); end
      end
      checks++; if (seq_err !== (k == 1)) begin errors++; $display("FAIL skip_seq_err step %0d got %b want %b", k, seq_err, (k == 1)); end
      checks++; if (locked !== (k == 5)) begin errors++; $display("FAIL skip_locked step %0d got %b want %b", k, locked, (k == 5)); end
    end
  endtask

  task automatic test_stall();
    while (pos != 3) tick_next();
    for (int t = 1; t <= 3; t++) begin
      tick(4'b0111);
      checks++; if (seq_err !== (t == 3)) begin errors++; $display("FAIL stall_seq_err hold %0d got %b want %b", t, seq_err, (t == 3)); end
      checks++; if (locked !== (t < 3)) begin errors++; $display("FAIL stall_locked hold %0d got %b want %b", t, locked, (t < 3)); end
    end
    checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL stall_err_cnt got %0d want 3", err_cnt); end
    pos = 4;
    for (int k = 1; k <= 5; k++) begin
      tick_next();
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL stall_resume_seq_err step %0d got %b want 0", k, seq_err); end
      checks++; if (locked !== (k == 5)) begin errors++; $display("FAIL stall_resume_locked step %0d got %b want %b", k, locked, (k == 5)); end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] exp_err;
    for (int i = 0; i < 260; i++) begin
      tick(4'b1010);
      for (int k = 1; k <= 6; k++) tick_next();
      exp_err = (4 + i > 255) ? 8'd255 : 8'(4 + i);
      checks++; if (err_cnt !== exp_err) begin errors++; $display("FAIL sat_err_cnt iter %0d got %0d want %0d", i, err_cnt, exp_err); end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked got %b want 1", locked); end
  endtask

  task automatic test_clr_err();
    tick(4'b1010);
    clr_err = 1'b1;
    tick_next();
    clr_err = 1'b0;
    checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL clr_seq_err got %b want 1", seq_err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL clr_err_cnt got %0d want 0", err_cnt); end
    for (int k = 2; k <= 6; k++) tick_next();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clr_relock got %b want 1", locked); end
    tick(4'b1010);
    tick_next();
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL clr_recount got %0d want 1", err_cnt); end
    for (int k = 2; k <= 6; k++) tick_next();
  endtask

  task automatic test_async_reset();
    checks++; if (locked !== 1'b1 || valid_out !== 1'b1) begin errors++; $display("FAIL arst_pre got locked=%b valid=%b want 1/1", locked, valid_out); end
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    checks++; if (idx_out !== 3'd0) begin errors++; $display("FAIL arst_idx got %0d want 0", idx_out); end
    checks++; if (onehot_out !== 8'h00) begin errors++; $display("FAIL arst_onehot got %h want 00", onehot_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", valid_out); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL arst_locked got %b want 0", locked); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL arst_seq_err got %b want 0", seq_err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL arst_err_cnt got %0d want 0", err_cnt); end
    @(negedge clk);
    n_rst = 1'b1;
    pos = 0;
    test_lock();
  endtask

  initial begin
    codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0011; codes[3] = 4'b0111;
    codes[4] = 4'b1111; codes[5] = 4'b1110; codes[6] = 4'b1100; codes[7] = 4'b1000;
    test_reset();
    test_lock();
    test_illegal();
    test_skip();
    test_stall();
    test_saturate();
    test_clr_err();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
